// File: rtl/mem_access_ctrl.sv
// Single-access MAR/MDR/memory sequencer with two-requester arbitration.
// Optional wait-state abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int DATA_PRIO   = 1,
  parameter int TIMEOUT_CYC = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic req0,
  input  logic wr0,
  input  logic req1,
  input  logic wr1,
  input  logic mem_ack,
  output logic gnt0,
  output logic gnt1,
  output logic MARin,
  output logic MDRin,
  output logic read,
  output logic mem_rd,
  output logic mem_wr,
  output logic done0,
  output logic done1,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_WR_DATA  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_RD_LATCH = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  if (2 ** TO_W <= TIMEOUT_CYC) begin : g_bad_to_w
    $error("TO_W too narrow to count to TIMEOUT_CYC");
  end

  state_t r_state;
  logic   r_dir;
  logic   r_gnt0;
  logic   r_gnt1;
  logic   r_marin;
  logic   r_mdrin;
  logic   r_read;
  logic   r_mem_rd;
  logic   r_mem_wr;
  logic   r_done0;
  logic   r_done1;
  logic   w_pick1;

`ifdef MEM_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
`endif

  // req1 wins when it is alone or when ties go to the data side
  assign w_pick1 = req1 & ((DATA_PRIO != 32'sd0) | ~req0);

  // Access sequencer; every output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_marin  <= 1'b0;
      r_mdrin  <= 1'b0;
      r_read   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_to_cnt <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_marin  <= 1'b0;
      r_mdrin  <= 1'b0;
      r_read   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_state <= S_ADDR;
            r_marin <= 1'b1;
            r_gnt1  <= w_pick1;
            r_gnt0  <= ~w_pick1;
            r_dir   <= w_pick1 ? wr1 : wr0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (r_dir) begin
            r_state <= S_WR_DATA;
            r_mdrin <= 1'b1;
          end else begin
            r_state  <= S_MEM_WAIT;
            r_mem_rd <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        S_WR_DATA: begin
          r_state  <= S_MEM_WAIT;
          r_mem_wr <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            if (r_dir) begin
              r_state <= S_DONE;
              r_done0 <= r_gnt0;
              r_done1 <= r_gnt1;
            end else begin
              r_state <= S_RD_LATCH;
              r_read  <= 1'b1;
              r_mdrin <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_to_cnt == TO_LAST) begin
            // abort: skip the MDR load and report the error with done
            r_state <= S_DONE;
            r_done0 <= r_gnt0;
            r_done1 <= r_gnt1;
            r_err   <= 1'b1;
          end
`endif
          else begin
            r_state  <= S_MEM_WAIT;
            r_mem_rd <= ~r_dir;
            r_mem_wr <= r_dir;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
          end
        end
        S_RD_LATCH: begin
          r_state <= S_DONE;
          r_done0 <= r_gnt0;
          r_done1 <= r_gnt1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign MARin  = r_marin;
  assign MDRin  = r_mdrin;
  assign read   = r_read;
  assign mem_rd = r_mem_rd;
  assign mem_wr = r_mem_wr;
  assign done0  = r_done0;
  assign done1  = r_done1;
`ifdef MEM_TIMEOUT_EN
  assign err    = r_err;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two DUTs (DATA_PRIO=0 and 1) driven by
// random accesses, a memory responder per DUT, and one per-cycle trace monitor.
module tb_mem_access_ctrl;

  localparam int NTX    = 40;
  localparam int TO_CYC = 15;
  localparam int NO_ACK = 100000;

  localparam logic [9:0] B_G0  = 10'h200;
  localparam logic [9:0] B_G1  = 10'h100;
  localparam logic [9:0] B_MAR = 10'h080;
  localparam logic [9:0] B_MDR = 10'h040;
  localparam logic [9:0] B_RD  = 10'h020;
  localparam logic [9:0] B_MRD = 10'h010;
  localparam logic [9:0] B_MWR = 10'h008;
  localparam logic [9:0] B_D0  = 10'h004;
  localparam logic [9:0] B_D1  = 10'h002;
  localparam logic [9:0] B_ERR = 10'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[2][$];
  int         len_q[2][$];
  int         dly_q[2][$];
  logic [1:0] act;
  int         rem[2];

  // Expected output sequence of one access, from grant to done.
  // kind 0: ack after d extra wait cycles; 1: timeout abort; 2: clr after d+1 wait cycles
  task automatic push_access(input int g, input int owner, input logic dir,
                             input int d, input int kind);
    logic [9:0] own;
    int n;
    int waits;
    own = (owner == 0) ? B_G0 : B_G1;
    n = 0;
    exp_q[g].push_back(own | B_MAR); n++;
    if (dir) begin exp_q[g].push_back(own | B_MDR); n++; end
    waits = (kind == 1) ? TO_CYC : d + 1;
    for (int i = 0; i < waits; i++) begin
      exp_q[g].push_back(own | (dir ? B_MWR : B_MRD)); n++;
    end
    if (kind == 0 && !dir) begin exp_q[g].push_back(own | B_RD | B_MDR); n++; end
    if (kind != 2) begin
      exp_q[g].push_back(own | ((owner == 0) ? B_D0 : B_D1) | ((kind == 1) ? B_ERR : 10'h000));
      n++;
    end
    len_q[g].push_back(n);
  endtask

  for (genvar G = 0; G < 2; G++) begin : g_env
    logic clr_s, req0_s, wr0_s, req1_s, wr1_s, ack_s, late_ack_s, fin, hung;
    logic gnt0_w, gnt1_w, marin_w, mdrin_w, read_w, mem_rd_w, mem_wr_w;
    logic done0_w, done1_w, err_w;
    logic [9:0] obs_w;

    mem_access_ctrl #(.DATA_PRIO(G), .TIMEOUT_CYC(TO_CYC), .TO_W(4)) u_dut (
      .clk(clk), .clr(clr_s), .req0(req0_s), .wr0(wr0_s), .req1(req1_s), .wr1(wr1_s),
      .mem_ack(ack_s), .gnt0(gnt0_w), .gnt1(gnt1_w), .MARin(marin_w), .MDRin(mdrin_w),
      .read(read_w), .mem_rd(mem_rd_w), .mem_wr(mem_wr_w), .done0(done0_w),
      .done1(done1_w), .err(err_w)
    );

    assign obs_w = {gnt0_w, gnt1_w, marin_w, mdrin_w, read_w, mem_rd_w, mem_wr_w,
                    done0_w, done1_w, err_w};

    // Memory model: acks d cycles into each wait, random stray acks elsewhere
    initial begin : resp
      int cnt;
      int d;
      logic inwait;
      ack_s = 1'b0; inwait = 1'b0; cnt = 0; d = 0;
      forever begin
        @(negedge clk);
        if (mem_rd_w | mem_wr_w) begin
          if (!inwait) begin
            inwait = 1'b1;
            cnt = 0;
            d = (dly_q[G].size() > 0) ? dly_q[G].pop_front() : NO_ACK;
          end
          ack_s = (cnt == d);
          cnt++;
        end else begin
          inwait = 1'b0;
          ack_s = late_ack_s | ($urandom_range(0, 3) == 0);
        end
      end
    end

    task automatic wait_dones(input bit need0, input bit need1);
      bit s0, s1;
      s0 = !need0;
      s1 = !need1;
      for (int c = 0; c < 200 && !(s0 && s1); c++) begin
        @(negedge clk);
        if (done0_w) begin s0 = 1'b1; req0_s = 1'b0; end
        if (done1_w) begin s1 = 1'b1; req1_s = 1'b0; end
      end
      if (!(s0 && s1)) begin hung = 1'b1; req0_s = 1'b0; req1_s = 1'b0; end
    endtask

    initial begin : stim
      int mode, d0, d1, k;
      logic dr0, dr1;
      bit seen;
      clr_s = 1'b1; req0_s = 1'b0; wr0_s = 1'b0; req1_s = 1'b0; wr1_s = 1'b0;
      late_ack_s = 1'b0; fin = 1'b0; hung = 1'b0;
      repeat (3) @(negedge clk);
      clr_s = 1'b0;
      for (int t = 0; t < NTX; t++) begin
        mode = $urandom_range(0, 2);
        dr0 = 1'($urandom_range(0, 1));
        dr1 = 1'($urandom_range(0, 1));
        d0 = $urandom_range(0, 5);
        d1 = $urandom_range(0, 5);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (mode == 0) begin
          req0_s = 1'b1; wr0_s = dr0;
          push_access(G, 0, dr0, d0, 0); dly_q[G].push_back(d0);
          @(negedge clk);
          if ($urandom_range(0, 1) == 1) wr0_s = ~wr0_s;
          if ($urandom_range(0, 1) == 1) req0_s = 1'b0;
          wait_dones(1'b1, 1'b0);
        end else if (mode == 1) begin
          req1_s = 1'b1; wr1_s = dr1;
          push_access(G, 1, dr1, d1, 0); dly_q[G].push_back(d1);
          @(negedge clk);
          if ($urandom_range(0, 1) == 1) wr1_s = ~wr1_s;
          if ($urandom_range(0, 1) == 1) req1_s = 1'b0;
          wait_dones(1'b0, 1'b1);
        end else begin
          req0_s = 1'b1; wr0_s = dr0; req1_s = 1'b1; wr1_s = dr1;
          if (G != 0) begin
            push_access(G, 1, dr1, d1, 0); dly_q[G].push_back(d1);
            push_access(G, 0, dr0, d0, 0); dly_q[G].push_back(d0);
          end else begin
            push_access(G, 0, dr0, d0, 0); dly_q[G].push_back(d0);
            push_access(G, 1, dr1, d1, 0); dly_q[G].push_back(d1);
          end
          wait_dones(1'b1, 1'b1);
        end
      end
      // clr while waiting on memory, then a late ack that must be ignored
      for (int r = 0; r < 2; r++) begin
        repeat (2) @(negedge clk);
        dr0 = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 10);
        req0_s = 1'b1; wr0_s = dr0;
        push_access(G, 0, dr0, k, 2); dly_q[G].push_back(NO_ACK);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
          @(negedge clk);
          seen = mem_rd_w | mem_wr_w;
        end
        if (!seen) hung = 1'b1;
        repeat (k) @(negedge clk);
        clr_s = 1'b1; req0_s = 1'b0;
        @(negedge clk);
        clr_s = 1'b0; late_ack_s = 1'b1;
        repeat (2) @(negedge clk);
        late_ack_s = 1'b0;
      end
`ifdef MEM_TIMEOUT_EN
      for (int o = 0; o < 2; o++) begin
        repeat (2) @(negedge clk);
        dr0 = 1'($urandom_range(0, 1));
        if (o == 0) begin req0_s = 1'b1; wr0_s = dr0; end
        else begin req1_s = 1'b1; wr1_s = dr0; end
        push_access(G, o, dr0, 0, 1); dly_q[G].push_back(NO_ACK);
        wait_dones(o == 0, o == 1);
      end
`endif
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end

  task automatic check_env(input int g, input logic [9:0] obs);
    logic [9:0] e;
    if (obs[9] | obs[8]) begin
      if (!act[g]) begin
        act[g] = 1'b1;
        rem[g] = (len_q[g].size() > 0) ? len_q[g].pop_front() : 0;
      end
      n_vec++;
      if (rem[g] == 0) begin
        n_err++;
        $display("FAIL env%0d unexpected_cycle act=%b exp=idle", g, obs);
      end else begin
        e = exp_q[g].pop_front();
        rem[g]--;
        if (obs !== e) begin
          n_err++;
          $display("FAIL env%0d access_cycle act=%b exp=%b", g, obs, e);
        end
      end
    end else begin
      if (act[g]) begin
        act[g] = 1'b0;
        n_vec++;
        if (rem[g] != 0) begin
          n_err++;
          $display("FAIL env%0d access_short act=%0d_left exp=0_left", g, rem[g]);
          for (int i = 0; i < rem[g]; i++) void'(exp_q[g].pop_front());
          rem[g] = 0;
        end
      end
      n_vec++;
      if (obs !== 10'h000) begin
        n_err++;
        $display("FAIL env%0d idle_outputs act=%b exp=%b", g, obs, 10'h000);
      end
    end
  endtask

  initial begin : mon
    act = 2'b00;
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 50000 && !(g_env[0].fin && g_env[1].fin); c++) begin
      @(negedge clk);
      check_env(0, g_env[0].obs_w);
      check_env(1, g_env[1].obs_w);
    end
    n_vec++;
    if (!(g_env[0].fin && g_env[1].fin)) begin
      n_err++;
      $display("FAIL run_budget act=unfinished exp=finished");
    end
    n_vec++;
    if (g_env[0].hung || g_env[1].hung) begin
      n_err++;
      $display("FAIL done_wait act=timeout exp=done_pulse (env0=%b env1=%b)",
               g_env[0].hung, g_env[1].hung);
    end
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (len_q[g].size() != 0) begin
        n_err++;
        $display("FAIL env%0d leftover_accesses act=%0d exp=0", g, len_q[g].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
